// File: rtl/puf_bit_vote_if.sv
// Challenge/response handshake of the voting RO-PUF bit cell, plus the
// enable/output pins of the external ring-oscillator array.
`timescale 1ns/1ps
interface puf_bit_vote_if #(
  parameter int N_RO  = 32,
  parameter int SEL_W = $clog2(N_RO/2)
);
  logic               start;
  logic [2*SEL_W-1:0] chall;
  logic               resp;
  logic               tie;
  logic               busy;
  logic               finish;
  logic [N_RO-1:0]    ro_en;
  logic [N_RO-1:0]    ro_out;

  modport master (
    output start, chall, ro_out,
    input  resp, tie, busy, finish, ro_en
  );

  modport slave (
    input  start, chall, ro_out,
    output resp, tie, busy, finish, ro_en
  );
endinterface

// File: rtl/puf_bit_vote.sv
// RO-PUF response bit: races two challenge-selected ring oscillators N_VOTE
// times and reports the majority winner plus a sticky tie flag.
`timescale 1ns/1ps
module puf_bit_vote #(
  parameter int N_RO       = 32,
  parameter int SEL_W      = $clog2(N_RO/2),
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int N_VOTE     = 3
) (
  input  logic          clk,
  input  logic          rst,
  puf_bit_vote_if.slave bus
);
  localparam int HALF    = N_RO / 2;
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int REP_W   = $clog2(N_VOTE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_COMPARE, S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [TMR_W-1:0]   r_tmr, w_tmr_next;
  logic [REP_W-1:0]   r_rep, w_rep_next;
  logic [REP_W-1:0]   r_ones, w_ones_next;
  logic               r_tie_acc, w_tie_next;
  logic [2*SEL_W-1:0] r_chall_q, w_chall_next;
  logic               r_resp, r_tie, r_busy, r_finish, r_cnt_clr;
  logic [N_RO-1:0]    r_ro_en, w_en_next;
  logic [HALF-1:0]    w_bank1, w_bank2;
  logic               w_mux1, w_mux2, w_cnt_clr, w_run_next;
  logic [CNT_W-1:0]   r_cnt1, r_cnt2;
  logic [CNT_W-1:0]   r_c1_m, r_c1_s, r_c2_m, r_c2_s;

  assign w_run_next = (w_state_next == S_RUN);

  // One-hot enable per bank; the challenge only changes while every RO is off.
  generate
    for (genvar gi = 0; gi < HALF; gi++) begin : g_bank
      assign w_en_next[gi]      = w_run_next && (r_chall_q[SEL_W-1:0] == SEL_W'(gi));
      assign w_en_next[HALF+gi] = w_run_next && (r_chall_q[2*SEL_W-1:SEL_W] == SEL_W'(gi));
      assign w_bank1[gi]        = bus.ro_out[gi];
      assign w_bank2[gi]        = bus.ro_out[HALF+gi];
    end
  endgenerate

  assign w_mux1    = w_bank1[r_chall_q[SEL_W-1:0]];
  assign w_mux2    = w_bank2[r_chall_q[2*SEL_W-1:SEL_W]];
  assign w_cnt_clr = r_cnt_clr | rst;

  always_ff @(posedge w_mux1 or posedge w_cnt_clr) begin
    if (w_cnt_clr)         r_cnt1 <= '0;
    else if (r_cnt1 != '1) r_cnt1 <= r_cnt1 + 1'b1;
  end

  always_ff @(posedge w_mux2 or posedge w_cnt_clr) begin
    if (w_cnt_clr)         r_cnt2 <= '0;
    else if (r_cnt2 != '1) r_cnt2 <= r_cnt2 + 1'b1;
  end

  // Counts are frozen through SETTLE, so a plain 2-flop bus sync is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c1_m <= '0;
      r_c1_s <= '0;
      r_c2_m <= '0;
      r_c2_s <= '0;
    end else begin
      r_c1_m <= r_cnt1;
      r_c1_s <= r_c1_m;
      r_c2_m <= r_cnt2;
      r_c2_s <= r_c2_m;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tmr_next   = r_tmr;
    w_rep_next   = r_rep;
    w_ones_next  = r_ones;
    w_tie_next   = r_tie_acc;
    w_chall_next = r_chall_q;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_chall_next = bus.chall;
          w_rep_next   = '0;
          w_ones_next  = '0;
          w_tie_next   = 1'b0;
          w_state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_tmr_next   = '0;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (r_tmr == TMR_W'(WIN_CYC - 1)) begin
          w_tmr_next   = '0;
          w_state_next = S_SETTLE;
        end else begin
          w_tmr_next = r_tmr + 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_tmr == TMR_W'(SETTLE_CYC - 1)) begin
          w_tmr_next   = '0;
          w_state_next = S_COMPARE;
        end else begin
          w_tmr_next = r_tmr + 1'b1;
        end
      end
      S_COMPARE: begin
        if (r_c1_s > r_c2_s)       w_ones_next = r_ones + 1'b1;
        else if (r_c1_s == r_c2_s) w_tie_next  = 1'b1;
        w_rep_next   = r_rep + 1'b1;
        w_state_next = (r_rep == REP_W'(N_VOTE - 1)) ? S_DONE : S_CLEAR;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_rep     <= '0;
      r_ones    <= '0;
      r_tie_acc <= 1'b0;
      r_chall_q <= '0;
      r_resp    <= 1'b0;
      r_tie     <= 1'b0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_ro_en   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tmr     <= w_tmr_next;
      r_rep     <= w_rep_next;
      r_ones    <= w_ones_next;
      r_tie_acc <= w_tie_next;
      r_chall_q <= w_chall_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_finish  <= (w_state_next == S_DONE);
      r_cnt_clr <= (w_state_next == S_CLEAR);
      r_ro_en   <= w_en_next;
      // Results are registered on entry to DONE so they line up with finish.
      if (w_state_next == S_DONE) begin
        r_resp <= (w_ones_next > REP_W'(N_VOTE / 2));
        r_tie  <= w_tie_next;
      end
    end
  end

  assign bus.resp   = r_resp;
  assign bus.tie    = r_tie;
  assign bus.busy   = r_busy;
  assign bus.finish = r_finish;
  assign bus.ro_en  = r_ro_en;
endmodule
